data_mem_responder: RTL

//  Data-memory responder for the execute stage's load/store ports. Services mem_ro (load) and
//  mem_wo (store) requests against a single-port word RAM. Stores are posted into a FIFO store

---
 rtl/data_mem_responder_if.sv | 38 +++
 rtl/data_mem_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store port bundle between the execute stage and data_mem_responder.
// The master drives requests; the slave (responder) returns load data and stall.
interface data_mem_responder_if;

    logic        mem_ro_port_enable;
    logic [15:0] mem_ro_port_address;
    logic        mem_wo_port_enable;
    logic [15:0] mem_wo_port_address;
    logic [15:0] mem_wo_port_value;
    logic [15:0] mem_ro_port_value;
    logic        mem_ro_port_valid;
    logic        mem_stall;

    // Execute-stage side: issues loads and stores, holds them while stalled
    modport master (
        output mem_ro_port_enable,
        output mem_ro_port_address,
        output mem_wo_port_enable,
        output mem_wo_port_address,
        output mem_wo_port_value,
        input  mem_ro_port_value,
        input  mem_ro_port_valid,
        input  mem_stall
    );

    // Memory side: accepts requests, answers loads one cycle later
    modport slave (
        input  mem_ro_port_enable,
        input  mem_ro_port_address,
        input  mem_wo_port_enable,
        input  mem_wo_port_address,
        input  mem_wo_port_value,
        output mem_ro_port_value,
        output mem_ro_port_valid,
        output mem_stall
    );

endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: single-port word RAM behind a posted FIFO store buffer.
// Loads answer one cycle after acceptance; stores drain to the RAM in cycles
// where no load uses the port, or unconditionally once the buffer is full.
// Build option: define DATA_MEM_FORWARD_EN for store-to-load forwarding out of
// the store buffer. Without it, a load that hits a buffered address stalls
// until the matching entries have drained, so load data always comes from RAM.
// mem_stall is a combinational output (the forwarding-less build folds the
// current load request into it).
module data_mem_responder #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned SB_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned BUS_AW    = 16;
    localparam int unsigned PTR_W     = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned RAM_WORDS = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

    // Storage
    logic [DATA_W-1:0] r_ram [RAM_WORDS];
    sb_entry_t         r_sb  [SB_DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    // Response registers
    logic [DATA_W-1:0] r_ro_value;
    logic              r_ro_valid;

    // Request decode and arbitration
    logic [ADDR_W-1:0] w_ro_addr;
    logic [ADDR_W-1:0] w_wo_addr;
    logic              w_full;
    logic              w_empty;
    logic              w_hit;
    logic              w_stall;
    logic              w_load_acc;
    logic              w_store_acc;
    logic              w_drain;
    sb_entry_t         w_head_entry;
    sb_entry_t         w_new_entry;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] w_load_result;
`ifdef DATA_MEM_FORWARD_EN
    logic [DATA_W-1:0] w_hit_data;
`endif
    logic              w_unused_addr_hi;

    // Only the low ADDR_W address bits select a word; the rest alias
    assign w_ro_addr        = bus.mem_ro_port_address[ADDR_W-1:0];
    assign w_wo_addr        = bus.mem_wo_port_address[ADDR_W-1:0];
    assign w_unused_addr_hi = &{1'b0,
                                bus.mem_ro_port_address[BUS_AW-1:ADDR_W],
                                bus.mem_wo_port_address[BUS_AW-1:ADDR_W]};

    assign w_full       = (r_count == CNT_W'(SB_DEPTH));
    assign w_empty      = (r_count == CNT_W'(0));
    assign w_head_entry = r_sb[r_head];
    assign w_new_entry  = '{addr: w_wo_addr, data: bus.mem_wo_port_value};

    // Search live buffer entries oldest to youngest so the youngest match wins
    always_comb begin
        w_hit = 1'b0;
`ifdef DATA_MEM_FORWARD_EN
        w_hit_data = '0;
`endif
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            if ((CNT_W'(i) < r_count) &&
                (r_sb[r_head + PTR_W'(i)].addr == w_ro_addr)) begin
                w_hit = 1'b1;
`ifdef DATA_MEM_FORWARD_EN
                w_hit_data = r_sb[r_head + PTR_W'(i)].data;
`endif
            end
        end
    end

    // Stall: buffer full, or (no forwarding) a load that must wait for a drain
`ifdef DATA_MEM_FORWARD_EN
    assign w_stall = w_full;
`else
    assign w_stall = w_full | (bus.mem_ro_port_enable & w_hit);
`endif

    assign w_load_acc  = bus.mem_ro_port_enable & ~w_stall;
    assign w_store_acc = bus.mem_wo_port_enable & ~w_stall;

    // RAM port: an accepted load owns it; otherwise the head drains if present.
    // A full buffer never accepts a load, so draining is forced there.
    assign w_drain = ~rst & ~w_empty & ~w_load_acc;

    // Load data: forwarded from the buffer when enabled and hit, else RAM
    assign w_rd_data = r_ram[w_ro_addr];
`ifdef DATA_MEM_FORWARD_EN
    assign w_load_result = w_hit ? w_hit_data : w_rd_data;
`else
    assign w_load_result = w_rd_data;
`endif

    // Store-buffer pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_store_acc) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_drain) begin
                r_head <= r_head + PTR_W'(1);
            end
            unique case ({w_store_acc, w_drain})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Store-buffer payload; entries beyond count are don't-care
    always_ff @(posedge clk) begin
        if (!rst && w_store_acc) begin
            r_sb[r_tail] <= w_new_entry;
        end
    end

    // RAM write port, fed only by the buffer head
    always_ff @(posedge clk) begin
        if (w_drain) begin
            r_ram[w_head_entry.addr] <= w_head_entry.data;
        end
    end

    // Load response: one-cycle valid pulse, value holds its last result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ro_value <= '0;
            r_ro_valid <= 1'b0;
        end else begin
            r_ro_valid <= w_load_acc;
            if (w_load_acc) begin
                r_ro_value <= w_load_result;
            end
        end
    end

    assign bus.mem_ro_port_value = r_ro_value;
    assign bus.mem_ro_port_valid = r_ro_valid;
    assign bus.mem_stall         = w_stall;

endmodule
